// File: rtl/unidad_control_pkg.sv
// Shared types and constants for the control unit: opcodes, FSM states,
// flag bit positions and the datapath control-word layout.
package unidad_control_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_ALU   = 4'h1,
        OP_SHIFT = 4'h2,
        OP_LOAD  = 4'h3,
        OP_STORE = 4'h4,
        OP_JMP   = 4'h8,
        OP_BRZ   = 4'h9,
        OP_BRN   = 4'hA,
        OP_BRC   = 4'hB,
        OP_BRV   = 4'hC,
        OP_HALT  = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEMWAIT,
        S_HALT
    } state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int CW_A_LSB = 14;
    localparam int CW_B_LSB = 12;
    localparam int CW_D_LSB = 10;
    localparam int CW_WE    = 9;
    localparam int CW_MB    = 8;
    localparam int CW_G_LSB = 4;
    localparam int CW_H_LSB = 2;
    localparam int CW_MF    = 1;
    localparam int CW_MD    = 0;

    // Field order matches the CW_* positions above, MSB first.
    typedef struct packed {
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] d;
        logic       we;
        logic       mb_sel;
        logic [3:0] g;
        logic [1:0] h;
        logic       mf_sel;
        logic       md_sel;
    } ctrl_t;

endpackage

// File: rtl/decodificador_ctrl.sv
// Pure combinational map from the instruction register to the datapath
// control word; LOAD leaves we=0 so the FSM can gate it with mem_ready.
module decodificador_ctrl
    import unidad_control_pkg::*;
(
    input  logic [15:0] ir,
    output logic [15:0] ctrl
);

    ctrl_t c;

    always_comb begin
        c = '0;
        case (opcode_e'(ir[15:12]))
            OP_ALU: begin
                c.a      = ir[9:8];
                c.b      = ir[7:6];
                c.d      = ir[11:10];
                c.we     = 1'b1;
                c.mb_sel = ir[1];
                c.g      = ir[5:2];
            end
            OP_SHIFT: begin
                c.a      = ir[9:8];
                c.b      = ir[7:6];
                c.d      = ir[11:10];
                c.we     = 1'b1;
                c.mb_sel = ir[1];
                c.h      = ir[3:2];
                c.mf_sel = 1'b1;
            end
            OP_LOAD: begin
                c.a      = ir[9:8];
                c.d      = ir[11:10];
                c.md_sel = 1'b1;
            end
            OP_STORE: begin
                c.a      = ir[9:8];
                c.b      = ir[7:6];
                c.mb_sel = 1'b1;
            end
            default: ;
        endcase
    end

    assign ctrl = c;

endmodule

// File: rtl/unidad_control.sv
// Multi-cycle control FSM: fetch/decode/execute with a memory wait state,
// program counter, branch flags snapshot and halt.
module unidad_control
    import unidad_control_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    input  logic [3:0]      stateBits,
    input  logic            mem_ready,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic [15:0]     ctrl_word,
    output logic            halted
);

    state_e          state;
    logic [PC_W-1:0] pc;
    logic [15:0]     ir;
    logic [3:0]      flags_q;
    logic            upd_flags;
    logic            take_branch;
    logic [15:0]     dec_ctrl;
    opcode_e         op;

    assign op        = opcode_e'(ir[15:12]);
    assign imem_addr = pc;

    decodificador_ctrl u_dec (
        .ir   (ir),
        .ctrl (dec_ctrl)
    );

    always_comb begin
        take_branch = 1'b0;
        case (op)
            OP_JMP: take_branch = 1'b1;
            OP_BRZ: take_branch = flags_q[FLAG_Z];
            OP_BRN: take_branch = flags_q[FLAG_N];
            OP_BRC: take_branch = flags_q[FLAG_C];
            OP_BRV: take_branch = flags_q[FLAG_V];
            default: ;
        endcase
    end

    // Only the LOAD write-enable follows mem_ready directly; everything else is state-decoded.
    always_comb begin
        ctrl_word = 16'h0000;
        if (state == S_EXEC || state == S_MEMWAIT)
            ctrl_word = dec_ctrl;
        if (state == S_MEMWAIT && op == OP_LOAD)
            ctrl_word[CW_WE] = mem_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            pc        <= '0;
            ir        <= '0;
            flags_q   <= '0;
            upd_flags <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            halted    <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    // Datapath flags settle one cycle after an ALU/SHIFT write.
                    if (upd_flags)
                        flags_q <= stateBits;
                    upd_flags <= 1'b0;
                    state     <= S_DECODE;
                end
                S_DECODE: begin
                    ir    <= imem_data;
                    pc    <= pc + PC_W'(1);
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    state <= S_FETCH;
                    case (op)
                        OP_ALU, OP_SHIFT: upd_flags <= 1'b1;
                        OP_LOAD: begin
                            mem_rd <= 1'b1;
                            state  <= S_MEMWAIT;
                        end
                        OP_STORE: begin
                            mem_wr <= 1'b1;
                            state  <= S_MEMWAIT;
                        end
                        OP_HALT: begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end
                        default: if (take_branch) pc <= ir[PC_W-1:0];
                    endcase
                end
                S_MEMWAIT: begin
                    if (mem_ready) begin
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        state  <= S_FETCH;
                    end
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_unidad_control.sv
// Directed-vector bench for unidad_control with a registered instruction memory model.
module tb_unidad_control;

    localparam int PC_W = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_data = 16'h0000;
    logic [3:0]      stateBits = 4'b0000;
    logic            mem_ready = 1'b0;
    logic            mem_rd, mem_wr, halted;
    logic [15:0]     ctrl_word;

    logic [15:0] imem [256];

    int checks = 0;
    int failures = 0;

    unidad_control #(.PC_W(PC_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .stateBits (stateBits),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .ctrl_word (ctrl_word),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= imem[imem_addr];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic clr_mem;
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Sequential fetch of ALU words with all-zero fields
        clr_mem();
        for (int i = 0; i < 4; i++) imem[i] = 16'h1000;
        do_reset();
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("seq_fetch_addr", 32'(imem_addr), 32'(i));
            chk("seq_fetch_ctrl", 32'(ctrl_word), 32'h0000);
            cyc(1);
            chk("seq_decode_ctrl", 32'(ctrl_word), 32'h0000);
            cyc(1);
            chk("seq_exec_ctrl", 32'(ctrl_word), 32'h0200);
            cyc(1);
        end

        // ALU and SHIFT control words
        clr_mem();
        imem[0] = 16'h1E5A;
        imem[1] = 16'h2E5A;
        do_reset();
        cyc(2);
        chk("alu_ctrl", 32'(ctrl_word), 32'h9F60);
        cyc(3);
        chk("shift_ctrl", 32'(ctrl_word), 32'h9F0A);

        // LOAD with three wait cycles
        clr_mem();
        imem[0] = 16'h3900;
        mem_ready = 1'b0;
        do_reset();
        cyc(1);
        chk("ld_decode_rd", 32'(mem_rd), 32'd0);
        cyc(1);
        chk("ld_exec_ctrl", 32'(ctrl_word), 32'h4801);
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            chk("ld_wait_rd", 32'(mem_rd), 32'd1);
            chk("ld_wait_ctrl", 32'(ctrl_word), 32'h4801);
        end
        cyc(1);
        mem_ready = 1'b1;
        #1;
        chk("ld_ready_rd", 32'(mem_rd), 32'd1);
        chk("ld_ready_ctrl", 32'(ctrl_word), 32'h4A01);
        cyc(1);
        chk("ld_after_rd", 32'(mem_rd), 32'd0);
        chk("ld_after_addr", 32'(imem_addr), 32'h01);
        chk("ld_after_ctrl", 32'(ctrl_word), 32'h0000);
        mem_ready = 1'b0;

        // Branches on the flag snapshot
        clr_mem();
        stateBits = 4'b0100;
        imem[0] = 16'h1000;
        imem[1] = 16'h9040;
        do_reset();
        cyc(6);
        chk("brz_taken", 32'(imem_addr), 32'h40);
        imem[1] = 16'hA040;
        do_reset();
        cyc(6);
        chk("brn_fall", 32'(imem_addr), 32'h02);
        imem[0] = 16'h0000;
        imem[1] = 16'h9040;
        do_reset();
        cyc(6);
        chk("brz_no_snapshot", 32'(imem_addr), 32'h02);
        stateBits = 4'b0010;
        imem[0] = 16'h2000;
        imem[1] = 16'hB040;
        do_reset();
        cyc(6);
        chk("brc_taken", 32'(imem_addr), 32'h40);
        stateBits = 4'b0000;

        // PC wrap from 0xFF
        clr_mem();
        imem[0] = 16'h80FF;
        do_reset();
        cyc(3);
        chk("jmp_ff", 32'(imem_addr), 32'hFF);
        cyc(3);
        chk("pc_wrap", 32'(imem_addr), 32'h00);

        // Reset during STORE wait, then HALT
        clr_mem();
        imem[0] = 16'h4180;
        mem_ready = 1'b0;
        do_reset();
        cyc(3);
        chk("st_wait_wr", 32'(mem_wr), 32'd1);
        chk("st_wait_rd", 32'(mem_rd), 32'd0);
        chk("st_wait_ctrl", 32'(ctrl_word), 32'h6100);
        cyc(1);
        chk("st_hold_wr", 32'(mem_wr), 32'd1);
        chk("st_hold_ctrl", 32'(ctrl_word), 32'h6100);
        reset = 1'b1;
        cyc(1);
        chk("st_abort_wr", 32'(mem_wr), 32'd0);
        chk("st_abort_addr", 32'(imem_addr), 32'h00);
        chk("st_abort_ctrl", 32'(ctrl_word), 32'h0000);
        imem[0] = 16'hF000;
        reset = 1'b0;
        cyc(3);
        for (int k = 0; k < 10; k++) begin
            chk("halt_flag", 32'(halted), 32'd1);
            chk("halt_addr", 32'(imem_addr), 32'h01);
            chk("halt_ctrl", 32'(ctrl_word), 32'h0000);
            cyc(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
